mem_arbiter: RTL and testbench

Two-port arbiter that shares the single instruction/data memory port between the fetch stage (instruction reads) and the memory stage (data loads/stores). It registers each request, drives one memory transaction at a time, returns data with a one-cycle acknowledge to the winning requester, and aborts transactions the memory never acknowledges. It sits between the core pipeline and the memory controller.

---
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data load/store, with timeout abort.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration (default: data has fixed priority).
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_inst_req,
    input  logic [31:0] i_inst_req_addr,
    output logic [31:0] or_inst_data,
    output logic        or_inst_ack,
    input  logic        i_data_req,
    input  logic        i_data_we,
    input  logic [31:0] i_data_addr,
    input  logic [31:0] i_data_wdata,
    input  logic [3:0]  i_data_be,
    output logic [31:0] or_data_rdata,
    output logic        or_data_ack,
    output logic        or_mem_req,
    output logic        or_mem_we,
    output logic [31:0] or_mem_addr,
    output logic [31:0] or_mem_wdata,
    output logic [3:0]  or_mem_be,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        or_bus_err
);
    typedef enum logic [1:0] {IDLE, INST, DATA, RESP} state_t;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [31:0] NOP = 32'h0000_0013;
    state_t state, state_nxt;
    logic [15:0] cnt;
    logic grant_data, grant_any, busy, done;
    assign grant_any = i_inst_req | i_data_req;
    assign busy = (state == INST) || (state == DATA);
    assign done = i_mem_ack || (cnt == TO_LAST);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_inst;
    assign grant_data = i_data_req & (~i_inst_req | last_inst);
    // remember which requester won most recently so contention alternates
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            last_inst <= 1'b1;
        else if (state == IDLE && grant_any)
            last_inst <= ~grant_data;
    end
`else
    assign grant_data = i_data_req;
`endif
    // state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    // next state: grant from IDLE, finish on ack or timeout, one response cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = grant_any ? (grant_data ? DATA : INST) : IDLE;
            INST,
            DATA:    state_nxt = done ? RESP : state;
            default: state_nxt = IDLE;
        endcase
    end
    // memory port, timeout counter and response registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt           <= '0;
            or_mem_req    <= 1'b0;
            or_mem_we     <= 1'b0;
            or_mem_addr   <= '0;
            or_mem_wdata  <= '0;
            or_mem_be     <= '0;
            or_inst_data  <= '0;
            or_inst_ack   <= 1'b0;
            or_data_rdata <= '0;
            or_data_ack   <= 1'b0;
            or_bus_err    <= 1'b0;
        end else begin
            or_inst_ack <= 1'b0;
            or_data_ack <= 1'b0;
            or_bus_err  <= 1'b0;
            if (state == IDLE && grant_any) begin
                cnt          <= '0;
                or_mem_req   <= 1'b1;
                or_mem_we    <= grant_data & i_data_we;
                or_mem_addr  <= grant_data ? i_data_addr : i_inst_req_addr;
                or_mem_wdata <= grant_data ? i_data_wdata : 32'h0;
                or_mem_be    <= grant_data ? i_data_be : 4'hF;
            end
            if (busy) begin
                cnt <= cnt + 16'd1;
                if (done) begin
                    or_mem_req <= 1'b0;
                    or_bus_err <= ~i_mem_ack;
                    if (state == DATA) begin
                        or_data_ack   <= 1'b1;
                        or_data_rdata <= i_mem_ack ? i_mem_rdata : 32'h0;
                    end else begin
                        or_inst_ack  <= 1'b1;
                        or_inst_data <= i_mem_ack ? i_mem_rdata : NOP;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a memory responder and response monitor.
module tb_mem_arbiter;
    localparam int TO = 4;
    logic        i_clk = 1'b0, i_rst_n = 1'b0;
    logic        i_inst_req = 1'b0, i_data_req = 1'b0, i_data_we = 1'b0, i_mem_ack = 1'b0;
    logic [31:0] i_inst_req_addr = '0, i_data_addr = '0, i_data_wdata = '0, i_mem_rdata = '0;
    logic [3:0]  i_data_be = '0;
    logic [31:0] or_inst_data, or_data_rdata, or_mem_addr, or_mem_wdata;
    logic        or_inst_ack, or_data_ack, or_mem_req, or_mem_we, or_bus_err;
    logic [3:0]  or_mem_be;

    mem_arbiter #(.TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_inst_req(i_inst_req), .i_inst_req_addr(i_inst_req_addr),
        .or_inst_data(or_inst_data), .or_inst_ack(or_inst_ack),
        .i_data_req(i_data_req), .i_data_we(i_data_we), .i_data_addr(i_data_addr),
        .i_data_wdata(i_data_wdata), .i_data_be(i_data_be),
        .or_data_rdata(or_data_rdata), .or_data_ack(or_data_ack),
        .or_mem_req(or_mem_req), .or_mem_we(or_mem_we), .or_mem_addr(or_mem_addr),
        .or_mem_wdata(or_mem_wdata), .or_mem_be(or_mem_be),
        .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack), .or_bus_err(or_bus_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        logic [31:0] rdata;
    } tx_t;
    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    tx_t  mem_q[$];
    rsp_t rsp_q[$];
    int   n_vec = 0, n_miss = 0;
    bit   mem_off = 1'b0;
    bit   model_last_inst = 1'b1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic tx_t rand_tx(input bit port);
        tx_t t;
        t.port  = port;
        t.we    = port ? 1'($urandom) : 1'b0;
        t.addr  = $urandom;
        t.wdata = port ? $urandom : 32'h0;
        t.be    = port ? 4'($urandom) : 4'hF;
        t.lat   = $urandom_range(1, TO + 2);
        t.rdata = $urandom;
        return t;
    endfunction

    task automatic push(input tx_t t);
        rsp_t r;
        mem_q.push_back(t);
        r.port = t.port;
        r.err  = t.lat > TO;
        r.data = r.err ? (t.port ? 32'h0 : 32'h0000_0013) : t.rdata;
        rsp_q.push_back(r);
        model_last_inst = !t.port;
    endtask

    task automatic drive(input tx_t t);
        if (t.port) begin
            i_data_we = t.we; i_data_addr = t.addr; i_data_wdata = t.wdata; i_data_be = t.be;
            i_data_req = 1'b1;
        end else begin
            i_inst_req_addr = t.addr;
            i_inst_req = 1'b1;
        end
    endtask

    task automatic wait_ack(input bit port);
        int k = 0;
        do begin
            @(negedge i_clk);
            k++;
        end while (!(port ? or_data_ack : or_inst_ack) && k < 100);
        if (!(port ? or_data_ack : or_inst_ack)) begin
            n_vec++;
            n_miss++;
            $display("FAIL ack_wait: port %0d got no ack in %0d cycles", port, k);
        end
        if (port) i_data_req = 1'b0;
        else i_inst_req = 1'b0;
    endtask

    task automatic single(input tx_t t);
        push(t);
        drive(t);
        wait_ack(t.port);
    endtask

    task automatic pair(input tx_t ti, input tx_t td);
        bit dw;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        dw = model_last_inst;
`else
        dw = 1'b1;
`endif
        if (dw) begin push(td); push(ti); end
        else begin push(ti); push(td); end
        drive(ti);
        drive(td);
        wait_ack(dw);
        wait_ack(!dw);
    endtask

    // memory responder: checks the latched fields and request length, acks after the scripted latency
    initial begin
        tx_t e;
        int  n, exp_n;
        forever begin
            @(negedge i_clk);
            if (or_mem_req && !mem_off) begin
                if (mem_q.size() == 0) begin
                    chk("mem_unexpected_req", or_mem_req, 1'b0);
                end else begin
                    e = mem_q.pop_front();
                    chk("mem_fields", {or_mem_we, or_mem_addr, or_mem_wdata, or_mem_be},
                        {e.we, e.addr, e.wdata, e.be});
                    n = 0;
                    while (or_mem_req && n < 50) begin
                        n++;
                        i_mem_ack   = (n == e.lat);
                        i_mem_rdata = (n == e.lat) ? e.rdata : $urandom;
                        @(negedge i_clk);
                        i_mem_ack = 1'b0;
                    end
                    exp_n = (e.lat < TO) ? e.lat : TO;
                    chk("mem_req_cycles", n, exp_n);
                end
            end
        end
    end

    // response monitor: every ack or error pulse must match the next expected response
    initial begin
        rsp_t r;
        forever begin
            @(negedge i_clk);
            if (or_inst_ack || or_data_ack || or_bus_err) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_ack", {or_inst_ack, or_data_ack, or_bus_err}, 3'b000);
                end else begin
                    r = rsp_q.pop_front();
                    chk("response", {or_inst_ack, or_data_ack, or_bus_err, or_data_ack ? or_data_rdata : or_inst_data},
                        {!r.port, r.port, r.err, r.data});
                end
            end
        end
    end

    task automatic drain();
        int k = 0;
        while ((rsp_q.size() != 0 || mem_q.size() != 0) && k < 100) begin
            @(negedge i_clk);
            k++;
        end
        chk("queues_drained", rsp_q.size() + mem_q.size(), 0);
    endtask

    initial begin
        tx_t t, u;
        repeat (3) @(negedge i_clk);
        chk("reset_outputs", {or_inst_data, or_inst_ack, or_data_rdata, or_data_ack, or_mem_req, or_mem_we,
            or_mem_addr, or_mem_wdata, or_mem_be, or_bus_err}, '0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        t = rand_tx(1'b0); t.addr = 32'h0000_0100; t.lat = 2; t.rdata = 32'h0050_0093;
        single(t);
        t = rand_tx(1'b1); t.we = 1'b1; t.addr = 32'h0000_2000; t.wdata = 32'hDEAD_BEEF; t.be = 4'b0011; t.lat = 1;
        single(t);
        t = rand_tx(1'b0); t.lat = TO + 3;
        single(t);
        t = rand_tx(1'b0); t.lat = TO;
        single(t);
        t = rand_tx(1'b1); t.lat = TO + 1;
        single(t);
        pair(rand_tx(1'b0), rand_tx(1'b1));
        pair(rand_tx(1'b0), rand_tx(1'b1));
        for (int i = 0; i < 150; i++) begin
            case ($urandom % 3)
                0: single(rand_tx(1'b0));
                1: single(rand_tx(1'b1));
                default: pair(rand_tx(1'b0), rand_tx(1'b1));
            endcase
            repeat ($urandom % 3) @(negedge i_clk);
        end
        drain();
        mem_off = 1'b1;
        i_data_addr = 32'h0000_3000; i_data_we = 1'b1; i_data_req = 1'b1;
        repeat (2) @(negedge i_clk);
        chk("rst_pre_req", or_mem_req, 1'b1);
        i_rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", {or_inst_data, or_inst_ack, or_data_rdata, or_data_ack, or_mem_req, or_mem_we,
            or_mem_addr, or_mem_wdata, or_mem_be, or_bus_err}, '0);
        i_data_req = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'hCAFE_F00D;
        @(negedge i_clk);
        i_mem_ack = 1'b0;
        chk("rst_stray_ack", {or_inst_ack, or_data_ack, or_bus_err, or_mem_req}, 4'b0000);
        repeat (2) @(negedge i_clk);
        chk("rst_idle_after", {or_inst_ack, or_data_ack, or_bus_err, or_mem_req}, 4'b0000);
        mem_off = 1'b0;
        model_last_inst = 1'b1;
        t = rand_tx(1'b0);
        u = rand_tx(1'b1);
        pair(t, u);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
